// File: rtl/bus_datapath_seq.sv
// rtl/bus_datapath_seq.sv - parametrised single-bus ALU datapath with built-in T3/T4/T5 micro-sequencer
module bus_datapath_seq #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter bit R0_ZERO = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  input  logic             imm_sel,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  input  logic             ext_we,
  input  logic [AW-1:0]    ext_addr,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_NEG  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;

  typedef enum logic [1:0] {IDLE, T3, T4, T5} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [AW-1:0]      ra_q, rb_q, rc_q;
  logic               isel_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   y_q;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   hi_q, lo_q, res_q;
  logic               done_q, err_q;

  logic                      accept, reserved, wb_en, ext_ok;
  logic [WIDTH-1:0]          rd_rb, rd_rc, b_op, alu_lo;
  logic [SW-1:0]             shamt;
  logic [2*WIDTH-1:0]        dbl;
  logic signed [2*WIDTH-1:0] y_ext, b_ext, prod;

  // R0 is hard-wired to zero on every read port when R0_ZERO is set
  assign rd_rb    = (R0_ZERO && rb_q == '0) ? '0 : regs_q[rb_q];
  assign rd_rc    = (R0_ZERO && rc_q == '0) ? '0 : regs_q[rc_q];
  assign dbg_data = (R0_ZERO && dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  assign accept   = (state_q == IDLE) && start;
  assign reserved = (op_q > OP_NOT);
  assign wb_en    = (op_q <= OP_NOT) && (op_q != OP_MUL) && !(R0_ZERO && ra_q == '0);
  assign ext_ok   = ext_we && (state_q == IDLE) && !(R0_ZERO && ext_addr == '0);

  assign b_op  = isel_q ? imm_q : rd_rc;
  assign shamt = b_op[SW-1:0];
  assign dbl   = {y_q, y_q};
  assign y_ext = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q});
  assign b_ext = $signed({{WIDTH{b_op[WIDTH-1]}}, b_op});
  assign prod  = y_ext * b_ext;

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = res_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

  // sequencer state register
  always_ff @(posedge clock) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // sequencer next state: one fixed pass through T3, T4, T5 per accepted start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = T3;
      T3:      state_d = T4;
      T4:      state_d = T5;
      T5:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU: Y op B; only MUL fills the upper half of Z, reserved opcodes yield zero
  always_comb begin
    alu_lo = '0;
    case (op_q)
      OP_ADD:  alu_lo = y_q + b_op;
      OP_SUB:  alu_lo = y_q - b_op;
      OP_AND:  alu_lo = y_q & b_op;
      OP_OR:   alu_lo = y_q | b_op;
      OP_SHR:  alu_lo = y_q >> shamt;
      OP_SHL:  alu_lo = y_q << shamt;
      OP_SHRA: alu_lo = $unsigned($signed(y_q) >>> shamt);
      OP_ROR:  alu_lo = WIDTH'(dbl >> shamt);
      OP_ROL:  alu_lo = WIDTH'((dbl << shamt) >> WIDTH);
      OP_NEG:  alu_lo = -y_q;
      OP_NOT:  alu_lo = ~y_q;
      default: alu_lo = '0;
    endcase
    z_d = {{WIDTH{1'b0}}, alu_lo};
    if (op_q == OP_MUL) z_d = prod;
  end

  // instruction register, captured only when start is accepted
  always_ff @(posedge clock) begin
    if (!clear) begin
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      isel_q <= 1'b0;
      imm_q  <= '0;
    end else if (accept) begin
      op_q   <= opcode;
      ra_q   <= ra;
      rb_q   <= rb;
      rc_q   <= rc;
      isel_q <= imm_sel;
      imm_q  <= imm;
    end
  end

  // register file: host writes only while idle, instruction writeback in T5
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (ext_ok) begin
      regs_q[ext_addr] <= ext_data;
    end else if (state_q == T5 && wb_en) begin
      regs_q[ra_q] <= z_q[WIDTH-1:0];
    end
  end

  // bus transfers Y and Z plus the T5 completion outputs
  always_ff @(posedge clock) begin
    if (!clear) begin
      y_q    <= '0;
      z_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == T3) y_q <= rd_rb;
      if (state_q == T4) z_q <= z_d;
      if (state_q == T5) begin
        if (op_q == OP_MUL) begin
          hi_q <= z_q[2*WIDTH-1:WIDTH];
          lo_q <= z_q[WIDTH-1:0];
        end
        res_q  <= z_q[WIDTH-1:0];
        done_q <= 1'b1;
        err_q  <= reserved;
      end
    end
  end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
- Parametrised successor to the single-bus 32-bit datapath.
- Width and register count are generic, and a built-in micro-sequencer replaces the externally driven control strobes.
- On a `start` handshake it runs one register/immediate ALU instruction over the shared bus: Rb->Y, then (Rc|imm) op Y->Z, then Z->Ra or HI/LO. It then pulses `done`.
- A host preload port and a debug read port give the testbench and control unit direct register access.

Parameters:
- WIDTH, 32, data/bus width; power of 2, >=8.
- NREGS, 16, general register count; power of 2; AW = log2(NREGS).
- R0_ZERO, 1, when 1 R0 reads as 0 and writes to R0 are discarded.

Ports:
- clock  in  1  single clock, rising edge.
- clear  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only in IDLE.
- opcode  in  4  operation, sampled at acceptance.
- ra, rb, rc  in  AW each  destination / source A / source B indices, sampled at acceptance.
- imm_sel  in  1  1: second operand is imm instead of R[rc].
- imm  in  WIDTH  immediate operand, sampled at acceptance.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done for reserved opcode.
- result  out  WIDTH  last Z low word; holds until the next completion.
- hi, lo  out  WIDTH  HI/LO registers.
- ext_we  in  1  host register write.
- ext_addr  in  AW  host write index.
- ext_data  in  WIDTH  host write data.
- dbg_addr  in  AW  debug read index.
- dbg_data  out  WIDTH  combinational R[dbg_addr]; R0 reads 0 if R0_ZERO.

Behaviour:
- Reset, when clear=0 at a clock edge:
  - all registers, Y, Z, HI, LO and result go to 0;
  - state goes to IDLE;
  - busy, done and err go to 0.
  - Reset mid-instruction aborts with no register write and no done.
- States: IDLE -> T3 -> T4 -> T5 -> IDLE.
- Acceptance: start=1 in IDLE at edge N latches opcode, ra, rb, rc, imm_sel and imm into an internal IR. State becomes T3 at N.
- T3: Y <= R[rb].
- T4: Z <= ALU(Y, B), where B = imm_sel ? imm : R[rc]. Z is 2*WIDTH bits.
- T5:
  - MUL: HI <= Z[2W-1:W], LO <= Z[W-1:0], no Ra write.
  - Other valid opcodes: R[ra] <= Z[W-1:0].
  - result <= Z[W-1:0].
  - done <= 1 for the next cycle only; err <= 1 if reserved.
- Latency: done is high in the cycle after edge N+3; busy is high for 3 cycles.
- Back-to-back: start is accepted in the same cycle done is high.
- start while busy is ignored; it is not queued.
- Opcodes:
  - 0 ADD, 1 SUB (Y-B), 2 AND, 3 OR.
  - 4 SHR (logical), 5 SHL, 6 SHRA (arithmetic), 7 ROR, 8 ROL. Shift amount = B[log2(WIDTH)-1:0].
  - 9 MUL, signed WIDTH x WIDTH -> 2*WIDTH.
  - 10 NEG (-Y), 11 NOT (~Y); B is ignored.
  - 12-15 reserved: Z <= 0, no register or HI/LO write, result <= 0, err pulses with done.
- Arithmetic wraps modulo 2^WIDTH. For non-MUL ops, Z upper half = 0.
- Host port:
  - ext_we writes R[ext_addr] <= ext_data only in IDLE; it is ignored while busy.
  - ext_we and start in the same IDLE cycle: the write commits at that edge and T3 reads the new value.
- Register-index aliasing: ra==rb==rc is legal.
  - Sources are read in T3/T4 before the T5 write.
  - With R0_ZERO=1, ra=0 discards the write; done still pulses and result still updates.

Test Plan:
- Reset: preload R1=5, drive clear=0 for one edge -> dbg_data for R1 = 0, busy=0, done=0, hi=lo=0.
- ADD: preload R2=7, R3=9; start op=0, ra=1, rb=2, rc=3 -> busy for 3 cycles, done on the 4th cycle after acceptance, R1=16, result=16. The same op with imm_sel=1, imm=0xFFFFFFFF gives R1=6.
- MUL and shifts, WIDTH=32:
  - R2=0xFFFFFFFE (-2), R3=3, MUL -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - SHRA R2 by imm=33 -> shift 1 -> 0xFFFFFFFF.
  - ROL 0x80000001 by 1 -> 0x00000003.
- Boundaries:
  - ra=0 ADD with R0_ZERO=1 -> R0 reads 0, result=sum.
  - Reserved op 13 -> err and done together, no register change.
  - start during busy -> ignored.
  - start in the done cycle -> accepted.
- Host port concurrency:
  - ext_we to R2 during T4 -> R2 unchanged.
  - ext_we R2=100 coincident with start (rb=2) -> instruction uses 100.
- Abort: clear=0 in T4 -> no write to ra, no done, state IDLE. Then a new start completes normally.
- Parameter sweep WIDTH=16, NREGS=8: repeat the ADD/SUB wrap test, 0x8000-1 -> 0x7FFF, and the MUL case.
